// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Includes the round-robin pick used by both arbitration points.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int          NREQ    = 3;
  localparam int          DIGIT_W = 4;
  localparam logic [31:0] BCD_MAX = 32'd9999;
  localparam logic [15:0] BCD_SAT = 16'h9999;

  // The search begins at last+1 and wraps. Candidates are visited from the
  // lowest priority to the highest, so the final hit is the winner.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req,
                                         input logic [1:0]      last);
    logic [1:0] pick;
    int         cand;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(last) + k) % NREQ;
      if (req[cand]) pick = 2'(cand);
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] idx_onehot(input logic [1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) converter, 14 binary bits to 4 BCD digits.
// The start edge performs the first iteration. done pulses 14 cycles after start.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  logic [29:0] sh_q, sh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;

  // Add 3 to every digit that is 5 or more, then shift the whole word left.
  function automatic logic [29:0] dd_step(input logic [29:0] s);
    logic [29:0]        t;
    logic [DIGIT_W-1:0] dig;
    t = s;
    for (int d = 0; d < 4; d++) begin
      dig = t[14 + DIGIT_W*d +: DIGIT_W];
      if (dig >= 4'd5) t[14 + DIGIT_W*d +: DIGIT_W] = dig + 4'd3;
    end
    return t << 1;
  endfunction

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      sh_d  = dd_step({16'd0, bin});
      cnt_d = 4'd13;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d  = dd_step(sh_q);
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = sh_q[29:14];

endmodule

// File: rtl/seg_disp_sched.sv
// Round-robin scheduler that shares the 4-digit display among three requesters.
// It latches the winner's value, converts it to BCD and holds it for a minimum dwell.
//
// state | meaning
// IDLE  | no display work pending; arbitrate on any request
// CONV  | winner latched, BCD conversion running (15 cycles)
// HOLD  | new value on display, dwell counter running
module seg_disp_sched
  import seg_pkg::*;
#(
  parameter int HOLD_CYCLES = 10_000_000,
  parameter int CONV_BITS   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [32*NREQ-1:0] req_val,
  output logic [NREQ-1:0]   grant,
  output logic [1:0]        src,
  output logic [15:0]       bcd,
  output logic              bcd_valid,
  output logic              overflow,
  output logic              busy
);

  localparam int             HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      rr_q, rr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [1:0]      src_q, src_d;
  logic [15:0]     bcd_q, bcd_d;
  logic            bcd_valid_q, bcd_valid_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;
  logic [31:0]     val_q, val_d;
  logic [1:0]      idx_q, idx_d;
  logic [HCW-1:0]  hold_q, hold_d;

  logic [1:0]      arb_idx;
  logic [31:0]     arb_val;
  logic            conv_done;
  logic [15:0]     conv_bcd;

  assign arb_idx = rr_pick(req, rr_q);

  always_comb begin
    case (arb_idx)
      2'd1:    arb_val = req_val[63:32];
      2'd2:    arb_val = req_val[95:64];
      default: arb_val = req_val[31:0];
    endcase
  end

  // grant_q is high only in the first CONV cycle, so it doubles as the converter start.
  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (|grant_q),
    .bin   (val_q[CONV_BITS-1:0]),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = '0;
    src_d       = src_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    overflow_d  = overflow_q;
    val_d       = val_q;
    idx_d       = idx_q;
    hold_d      = hold_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = idx_onehot(arb_idx);
          val_d   = arb_val;
          idx_d   = arb_idx;
          rr_d    = arb_idx;
          state_d = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          src_d       = idx_q;
          overflow_d  = (val_q > BCD_MAX);
          bcd_d       = (val_q > BCD_MAX) ? BCD_SAT : conv_bcd;
          bcd_valid_d = 1'b1;
          hold_d      = HOLD_LOAD;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          if (|req) begin
            grant_d = idx_onehot(arb_idx);
            val_d   = arb_val;
            idx_d   = arb_idx;
            rr_d    = arb_idx;
            state_d = CONV;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_d = hold_q - HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 2'd2;
      grant_q     <= '0;
      src_q       <= 2'd0;
      bcd_q       <= 16'h0000;
      bcd_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      val_q       <= '0;
      idx_q       <= 2'd0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      src_q       <= src_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      val_q       <= val_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
    end
  end

  assign grant     = grant_q;
  assign src       = src_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed bench for seg_disp_sched with a short dwell (HOLD_CYCLES=4).
// A vector table covers single grants; hand sequences cover reset, fairness and late requests.
module tb_seg_disp_sched;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [31:0] v0, v1, v2;
  logic [95:0] req_val;
  logic [2:0]  grant;
  logic [1:0]  src;
  logic [15:0] bcd;
  logic        bcd_valid, overflow, busy;

  assign req_val = {v2, v1, v0};

  seg_disp_sched #(.HOLD_CYCLES(HOLD), .CONV_BITS(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_val   (req_val),
    .grant     (grant),
    .src       (src),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  req;
    logic [31:0] v0, v1, v2;
    logic [2:0]  g;
    logic [1:0]  src;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(output logic [2:0] g, output int n);
    g = '0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (grant != 3'b000) begin
        g = grant;
        break;
      end
    end
  endtask

  // Counts cycles to the next bcd_valid, and any grants seen on the way.
  task automatic wait_valid(output int n, output int gseen);
    n = 0;
    gseen = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (grant != 3'b000) gseen++;
      if (bcd_valid) break;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (!busy) break;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] g;
    int         n, gs, acc;

    vecs[0] = '{3'b001, 32'd1234, 32'd0,     32'd0,         3'b001, 2'd0, 16'h1234, 1'b0};
    vecs[1] = '{3'b100, 32'd0,    32'd0,     32'd0,         3'b100, 2'd2, 16'h0000, 1'b0};
    vecs[2] = '{3'b100, 32'd0,    32'd0,     32'd9999,      3'b100, 2'd2, 16'h9999, 1'b0};
    vecs[3] = '{3'b100, 32'd0,    32'd0,     32'd10000,     3'b100, 2'd2, 16'h9999, 1'b1};
    vecs[4] = '{3'b100, 32'd0,    32'd0,     32'hFFFF_FFFF, 3'b100, 2'd2, 16'h9999, 1'b1};
    vecs[5] = '{3'b011, 32'd5,    32'd4321,  32'd0,         3'b001, 2'd0, 16'h0005, 1'b0};
    vecs[6] = '{3'b011, 32'd5,    32'd4321,  32'd0,         3'b010, 2'd1, 16'h4321, 1'b0};
    vecs[7] = '{3'b110, 32'd0,    32'd70000, 32'd8191,      3'b100, 2'd2, 16'h8191, 1'b0};
    vecs[8] = '{3'b010, 32'd0,    32'd16384, 32'd0,         3'b010, 2'd1, 16'h9999, 1'b1};

    // Reset held with all requests high: nothing may be granted.
    rst = 1'b1;
    req = 3'b111;
    v0 = 32'd11; v1 = 32'd22; v2 = 32'd33;
    acc = 0;
    repeat (4) begin
      @(negedge clk);
      if (grant != 3'b000 || busy || bcd_valid) acc++;
    end
    check("rst_no_activity", 32'(acc), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0000);
    check("rst_src", 32'(src), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Fairness: requests stay high, grants rotate 001,010,100,001 19 cycles apart.
    rst = 1'b0;
    wait_grant(g, n);
    check("first_grant", 32'(g), 32'b001);
    check("first_grant_lat", 32'(n), 32'd1);
    wait_valid(n, gs);
    check("fair_valid_lat", 32'(n), 32'd15);
    check("fair_bcd0", 32'(bcd), 32'h0011);
    for (int k = 0; k < 3; k++) begin
      wait_grant(g, n);
      check($sformatf("fair_grant%0d", k + 1), 32'(g), (k == 0) ? 32'b010 : (k == 1) ? 32'b100 : 32'b001);
      check($sformatf("fair_gap%0d", k + 1), 32'(n), (k == 0) ? 32'd4 : 32'd19);
    end
    req = 3'b000;
    wait_idle(n);
    check("fair_drain", 32'(busy), 32'd0);

    // Table of single grants, starting from a fresh round-robin pointer.
    pulse_reset();
    foreach (vecs[i]) begin
      req = vecs[i].req;
      v0 = vecs[i].v0; v1 = vecs[i].v1; v2 = vecs[i].v2;
      wait_grant(g, n);
      req = 3'b000;
      check($sformatf("v%0d_grant", i), 32'(g), 32'(vecs[i].g));
      wait_valid(n, gs);
      check($sformatf("v%0d_latency", i), 32'(n), 32'd15);
      check($sformatf("v%0d_conv_grants", i), 32'(gs), 32'd0);
      check($sformatf("v%0d_bcd", i), 32'(bcd), 32'(vecs[i].bcd));
      check($sformatf("v%0d_src", i), 32'(src), 32'(vecs[i].src));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      wait_idle(n);
      check($sformatf("v%0d_hold", i), 32'(n), 32'(HOLD));
    end

    // Late request raised during HOLD is granted exactly at expiry.
    pulse_reset();
    req = 3'b001; v0 = 32'd1234; v1 = 32'd77;
    wait_grant(g, n);
    req = 3'b000;
    wait_valid(n, gs);
    req = 3'b010;
    wait_grant(g, n);
    check("late_grant", 32'(g), 32'b010);
    check("late_gap", 32'(n), 32'd4);
    check("late_busy", 32'(busy), 32'd1);
    req = 3'b000;
    wait_valid(n, gs);
    check("late_bcd", 32'(bcd), 32'h0077);
    check("late_src", 32'(src), 32'd1);
    wait_idle(n);

    // Late request withdrawn before expiry: back to IDLE, display untouched.
    req = 3'b001; v0 = 32'd5;
    wait_grant(g, n);
    req = 3'b000;
    check("wd_grant", 32'(g), 32'b001);
    wait_valid(n, gs);
    req = 3'b010;
    repeat (2) @(negedge clk);
    req = 3'b000;
    wait_idle(n);
    check("wd_idle", 32'(n), 32'd2);
    acc = 0;
    repeat (6) begin
      @(negedge clk);
      if (grant != 3'b000 || bcd_valid) acc++;
    end
    check("wd_no_grant", 32'(acc), 32'd0);
    check("wd_bcd", 32'(bcd), 32'h0005);

    // Reset in the middle of a conversion.
    req = 3'b001; v0 = 32'd4321;
    wait_grant(g, n);
    req = 3'b000;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_bcd", 32'(bcd), 32'h0000);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_outs", 32'({grant, src, bcd_valid, overflow}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    acc = 0;
    repeat (30) begin
      @(negedge clk);
      if (bcd_valid || busy) acc++;
    end
    check("abort_no_valid", 32'(acc), 32'd0);
    check("abort_bcd_hold", 32'(bcd), 32'h0000);
    req = 3'b010; v1 = 32'd2468;
    wait_grant(g, n);
    req = 3'b000;
    check("post_abort_grant", 32'(g), 32'b010);
    wait_valid(n, gs);
    check("post_abort_lat", 32'(n), 32'd15);
    check("post_abort_bcd", 32'(bcd), 32'h2468);
    wait_idle(n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
